// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

    localparam int ARB_AW      = 16;
    localparam int ARB_DW      = 32;
    localparam int ARB_TIMEOUT = 15;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester bus (cpu/dma side) and memory port bus for the arbiter.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
);
    logic            ren;
    logic            wen;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wmask;
    logic            gnt;
    logic [DW-1:0]   rdata;
    logic            rd_valid;
    logic            err;

    modport master (
        output ren, wen, addr, wdata, wmask,
        input  gnt, rdata, rd_valid, err
    );

    modport slave (
        input  ren, wen, addr, wdata, wmask,
        output gnt, rdata, rd_valid, err
    );
endinterface

interface mem_port_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
);
    logic            ren;
    logic            wen;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wmask;
    logic [DW-1:0]   rdata;
    logic            rd_valid;

    modport master (
        output ren, wen, addr, wdata, wmask,
        input  rdata, rd_valid
    );

    modport slave (
        input  ren, wen, addr, wdata, wmask,
        output rdata, rd_valid
    );
endinterface

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin pick: on a tie the master that did not win last goes.
module mem_arbiter_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        gnt    = 2'b00;
        unique case (req)
            2'b01: winner = 1'b0;
            2'b10: winner = 1'b1;
            2'b11: winner = ~last;
            default: winner = 1'b0;
        endcase
        if (req != 2'b00) begin
            gnt = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between cpu (m0) and loader/DMA (m1),
// with a single outstanding read, response routing and a read timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = ARB_AW,
    parameter int DW      = ARB_DW,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave m0,
    mem_arbiter_if.slave m1,
    mem_port_if.master   mem
);

    localparam int MW = DW / 8;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          winner;

    logic          sel_wen;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [MW-1:0] sel_wmask;

    logic [1:0]    gnt_o;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_data;

    // Requests are masked while in reset so no grant leaks out combinationally.
    assign req = {m1.ren | m1.wen, m0.ren | m0.wen} & {2{rst_n}};

    mem_arbiter_rr2 u_rr (
        .req    (req),
        .last   (last_q),
        .gnt    (gnt),
        .winner (winner)
    );

    assign sel_wen   = winner ? m1.wen   : m0.wen;
    assign sel_addr  = winner ? m1.addr  : m0.addr;
    assign sel_wdata = winner ? m1.wdata : m0.wdata;
    assign sel_wmask = winner ? m1.wmask : m0.wmask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= ARB_M0;
            last_q  <= ARB_M1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        mem.ren   = 1'b0;
        mem.wen   = 1'b0;
        mem.addr  = '0;
        mem.wdata = '0;
        mem.wmask = '1;
        gnt_o     = 2'b00;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    gnt_o     = gnt;
                    last_d    = winner;
                    mem.addr  = sel_addr;
                    mem.wdata = sel_wdata;
                    mem.wmask = sel_wmask;
                    if (sel_wen) begin
                        mem.wen = 1'b1;
                    end else begin
                        mem.ren = 1'b1;
                        owner_d = winner;
                        cnt_d   = '0;
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (mem.rd_valid) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem.rdata;
                    state_d   = ST_IDLE;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m0.gnt      = gnt_o[0];
    assign m1.gnt      = gnt_o[1];
    assign m0.rd_valid = rsp_valid && owner_q == ARB_M0;
    assign m1.rd_valid = rsp_valid && owner_q == ARB_M1;
    assign m0.err      = rsp_err && owner_q == ARB_M0;
    assign m1.err      = rsp_err && owner_q == ARB_M1;
    assign m0.rdata    = m0.rd_valid ? rsp_data : '0;
    assign m1.rdata    = m1.rd_valid ? rsp_data : '0;

    a_one_cmd: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem.ren && mem.wen));
    a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        !(m0.gnt && m1.gnt));
    a_one_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(m0.rd_valid && m1.rd_valid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench: expected events are queued with their cycle
// and a negedge monitor matches every grant/response the arbiter produces.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        mren;
        logic        mwen;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        v0;
        logic        e0;
        logic [31:0] d0;
        logic        v1;
        logic        e1;
        logic [31:0] d1;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    exp_t exp_q[$];

    mem_arbiter_if m0_if ();
    mem_arbiter_if m1_if ();
    mem_port_if    mem_if ();

    mem_arbiter #(
        .AW      (16),
        .DW      (32),
        .TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .mem   (mem_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t sample();
        obs_t s;
        s.g0    = m0_if.gnt;
        s.g1    = m1_if.gnt;
        s.mren  = mem_if.ren;
        s.mwen  = mem_if.wen;
        s.addr  = mem_if.addr;
        s.wdata = mem_if.wdata;
        s.wmask = mem_if.wmask;
        s.v0    = m0_if.rd_valid;
        s.e0    = m0_if.err;
        s.d0    = m0_if.rdata;
        s.v1    = m1_if.rd_valid;
        s.e1    = m1_if.err;
        s.d1    = m1_if.rdata;
        return s;
    endfunction

    function automatic obs_t idle_obs();
        obs_t s;
        s       = '0;
        s.wmask = 4'hF;
        return s;
    endfunction

    function automatic obs_t gnt_obs(logic m, logic wr, logic [15:0] a,
                                     logic [31:0] d, logic [3:0] mk);
        obs_t s;
        s       = idle_obs();
        s.g0    = !m;
        s.g1    = m;
        s.mren  = !wr;
        s.mwen  = wr;
        s.addr  = a;
        s.wdata = d;
        s.wmask = mk;
        return s;
    endfunction

    function automatic obs_t rsp_obs(logic m, logic [31:0] d, logic e);
        obs_t s;
        s = idle_obs();
        if (!m) begin
            s.v0 = 1'b1;
            s.e0 = e;
            s.d0 = d;
        end else begin
            s.v1 = 1'b1;
            s.e1 = e;
            s.d1 = d;
        end
        return s;
    endfunction

    task automatic push(int c, obs_t o);
        exp_t e;
        e.cyc = c;
        e.o   = o;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_if.ren       = 1'b0;
        m0_if.wen       = 1'b0;
        m0_if.addr      = '0;
        m0_if.wdata     = '0;
        m0_if.wmask     = '0;
        m1_if.ren       = 1'b0;
        m1_if.wen       = 1'b0;
        m1_if.addr      = '0;
        m1_if.wdata     = '0;
        m1_if.wmask     = '0;
        mem_if.rdata    = '0;
        mem_if.rd_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_direct(string name, obs_t exp);
        obs_t a;
        a = sample();
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, a, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        obs_t a;
        exp_t e;
        a = sample();
        checks++;
        if (a.g0 || a.g1 || a.v0 || a.v1 || a.e0 || a.e1) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got=%h", cyc, a);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.o !== a) begin
                    errors++;
                    $display("FAIL event cyc=%0d got=%h exp_cyc=%0d exp=%h",
                             cyc, a, e.cyc, e.o);
                end
            end
        end else if (a !== idle_obs()) begin
            errors++;
            $display("FAIL idle_bus cyc=%0d got=%h exp=%h",
                     cyc, a, idle_obs());
        end
    end

    initial begin
        int c;
        int i0;
        int i1;

        // reset with both masters requesting: nothing may leave the arbiter
        clear_inputs();
        rst_n       = 1'b0;
        m0_if.ren   = 1'b1;
        m1_if.wen   = 1'b1;
        m1_if.addr  = 16'h0999;
        @(negedge clk);
        check_direct("reset_outputs", idle_obs());
        tick();
        tick();
        clear_inputs();
        rst_n = 1'b1;

        // m0 read, data returned one cycle after the grant
        c = cyc;
        m0_if.ren  = 1'b1;
        m0_if.addr = 16'h0010;
        m0_if.wmask = 4'hF;
        push(c, gnt_obs(ARB_M0, 1'b0, 16'h0010, 32'h0, 4'hF));
        tick();
        m0_if.ren       = 1'b0;
        mem_if.rd_valid = 1'b1;
        mem_if.rdata    = 32'hDEADBEEF;
        push(c + 1, rsp_obs(ARB_M0, 32'hDEADBEEF, 1'b0));
        tick();
        clear_inputs();
        tick();

        // both masters writing every cycle: m0, m1, m0, m1
        do_reset();
        i0 = 0;
        i1 = 0;
        for (int i = 0; i < 4; i++) begin
            m0_if.wen   = 1'b1;
            m0_if.addr  = 16'(32'h0100 + i0);
            m0_if.wdata = 32'hA000_0000 + i0;
            m0_if.wmask = 4'hF;
            m1_if.wen   = 1'b1;
            m1_if.addr  = 16'(32'h0200 + i1);
            m1_if.wdata = 32'hB000_0000 + i1;
            m1_if.wmask = 4'b1100;
            if (i % 2 == 0) begin
                push(cyc, gnt_obs(ARB_M0, 1'b1, 16'(32'h0100 + i0),
                                  32'hA000_0000 + i0, 4'hF));
                i0++;
            end else begin
                push(cyc, gnt_obs(ARB_M1, 1'b1, 16'(32'h0200 + i1),
                                  32'hB000_0000 + i1, 4'b1100));
                i1++;
            end
            tick();
        end
        clear_inputs();
        tick();

        // m1 read outstanding blocks m0 write until the response
        do_reset();
        c = cyc;
        m1_if.ren   = 1'b1;
        m1_if.addr  = 16'h0040;
        m1_if.wmask = 4'hF;
        push(c, gnt_obs(ARB_M1, 1'b0, 16'h0040, 32'h0, 4'hF));
        tick();
        m1_if.ren   = 1'b0;
        m0_if.wen   = 1'b1;
        m0_if.addr  = 16'h0020;
        m0_if.wdata = 32'h12345678;
        m0_if.wmask = 4'hF;
        tick();
        tick();
        mem_if.rd_valid = 1'b1;
        mem_if.rdata    = 32'hCAFEF00D;
        push(c + 3, rsp_obs(ARB_M1, 32'hCAFEF00D, 1'b0));
        tick();
        mem_if.rd_valid = 1'b0;
        mem_if.rdata    = '0;
        push(c + 4, gnt_obs(ARB_M0, 1'b1, 16'h0020, 32'h12345678, 4'hF));
        tick();
        clear_inputs();
        tick();

        // read timeout: err pulse 15 cycles after grant, late data dropped
        do_reset();
        c = cyc;
        m0_if.ren   = 1'b1;
        m0_if.addr  = 16'h0050;
        m0_if.wmask = 4'hF;
        push(c, gnt_obs(ARB_M0, 1'b0, 16'h0050, 32'h0, 4'hF));
        push(c + 15, rsp_obs(ARB_M0, 32'h0, 1'b1));
        tick();
        clear_inputs();
        repeat (15) tick();
        mem_if.rd_valid = 1'b1;
        mem_if.rdata    = 32'hFFFFFFFF;
        tick();
        clear_inputs();
        tick();

        // reset two cycles into a read: immediate clear, no completion
        do_reset();
        c = cyc;
        m1_if.ren   = 1'b1;
        m1_if.addr  = 16'h0060;
        m1_if.wmask = 4'hF;
        push(c, gnt_obs(ARB_M1, 1'b0, 16'h0060, 32'h0, 4'hF));
        tick();
        m1_if.ren = 1'b0;
        tick();
        rst_n           = 1'b0;
        mem_if.rd_valid = 1'b1;
        mem_if.rdata    = 32'h11111111;
        #1;
        check_direct("reset_mid_read", idle_obs());
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_inputs();
        m1_if.ren   = 1'b1;
        m1_if.addr  = 16'h0070;
        m1_if.wmask = 4'hF;
        c = cyc;
        push(c, gnt_obs(ARB_M1, 1'b0, 16'h0070, 32'h0, 4'hF));
        tick();
        m1_if.ren       = 1'b0;
        mem_if.rd_valid = 1'b1;
        mem_if.rdata    = 32'h0BADF00D;
        push(c + 1, rsp_obs(ARB_M1, 32'h0BADF00D, 1'b0));
        tick();
        clear_inputs();
        tick();

        // ren and wen together act as a write and the arbiter stays idle
        do_reset();
        m0_if.ren   = 1'b1;
        m0_if.wen   = 1'b1;
        m0_if.addr  = 16'h0030;
        m0_if.wdata = 32'h55AA55AA;
        m0_if.wmask = 4'b0011;
        push(cyc, gnt_obs(ARB_M0, 1'b1, 16'h0030, 32'h55AA55AA, 4'b0011));
        tick();
        clear_inputs();
        m1_if.wen   = 1'b1;
        m1_if.addr  = 16'h0080;
        m1_if.wdata = 32'h01020304;
        m1_if.wmask = 4'hF;
        push(cyc, gnt_obs(ARB_M1, 1'b1, 16'h0080, 32'h01020304, 4'hF));
        tick();
        clear_inputs();
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
